iob_reset_sequencer: RTL and testbench



---
 rtl/iob_reset_sequencer.sv | 159 +++++++++++++++
 tb/tb_iob_reset_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/iob_reset_sequencer.sv
// Staged reset sequencer for the generated clock domain: qualifies PLL/MMCM lock,
// holds every downstream reset, then releases them one stage at a time (bit 0 first).
module iob_reset_sequencer #(
   parameter int N_STAGES    = 3,
   parameter int HOLD_CYCLES = 16,
   parameter int STAGE_GAP   = 8,
   parameter int LOCK_FILT   = 4
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                lock_i,
   input  logic                sw_rst_i,
   output logic [N_STAGES-1:0] rst_o,
   output logic                ready_o,
   output logic [2:0]          state_o,
   output logic [7:0]          lock_loss_cnt_o
);

   localparam int MAX_HG  = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
   localparam int CNT_MAX = (MAX_HG > LOCK_FILT) ? MAX_HG : LOCK_FILT;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [CNT_W-1:0]    HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0]    GAP_LAST  = CNT_W'(STAGE_GAP - 1);
   localparam logic [CNT_W-1:0]    FILT_LAST = CNT_W'(LOCK_FILT - 1);
   localparam logic [N_STAGES-1:0] ALL_ON    = {N_STAGES{1'b1}};

   typedef enum logic [2:0] {
      S_RESET     = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_HOLD      = 3'd2,
      S_RELEASE   = 3'd3,
      S_RUN       = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [N_STAGES-1:0] stage_q, stage_d;
   logic                ready_q, ready_d;
   logic [CNT_W-1:0]    filt_q, filt_d;
   logic [CNT_W-1:0]    phase_q, phase_d;
   logic [7:0]          loss_q, loss_d;
   logic [N_STAGES-1:0] shifted;
   logic                lock_meta, lock_sync;
   logic                lock_lost;

   // lock_i comes from the PLL/MMCM and is not related to clk_i.
   always_ff @(posedge clk_i) begin
      lock_meta <= lock_i;
      lock_sync <= lock_meta;
   end

   // filt_q counts consecutive lock=1 samples while waiting for lock, and
   // consecutive lock=0 samples once the sequence is under way.
   assign lock_lost = (filt_q == FILT_LAST) && !lock_sync;

   always_comb begin
      state_d = state_q;
      stage_d = stage_q;
      ready_d = ready_q;
      filt_d  = filt_q;
      phase_d = phase_q;
      loss_d  = loss_q;
      shifted = stage_q << 1;

      case (state_q)
         S_WAIT_LOCK: begin
            if (lock_sync) begin
               if (filt_q == FILT_LAST) begin
                  state_d = S_HOLD;
                  filt_d  = '0;
                  phase_d = '0;
               end else begin
                  filt_d = filt_q + 1'b1;
               end
            end else begin
               filt_d = '0;
            end
         end

         S_HOLD, S_RELEASE, S_RUN: begin
            if (lock_lost) begin
               state_d = S_WAIT_LOCK;
               stage_d = ALL_ON;
               ready_d = 1'b0;
               filt_d  = '0;
               phase_d = '0;
               loss_d  = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;
            end else if (sw_rst_i) begin
               state_d = lock_sync ? S_HOLD : S_WAIT_LOCK;
               stage_d = ALL_ON;
               ready_d = 1'b0;
               filt_d  = '0;
               phase_d = '0;
            end else begin
               filt_d = lock_sync ? '0 : filt_q + 1'b1;
               if (state_q == S_HOLD) begin
                  if (phase_q == HOLD_LAST) begin
                     phase_d = '0;
                     stage_d = ALL_ON << 1;
                     if ((ALL_ON << 1) == '0) begin
                        state_d = S_RUN;
                        ready_d = 1'b1;
                     end else begin
                        state_d = S_RELEASE;
                     end
                  end else begin
                     phase_d = phase_q + 1'b1;
                  end
               end else if (state_q == S_RELEASE) begin
                  // Shifting a zero in from the bottom keeps lower stages released first.
                  if (phase_q == GAP_LAST) begin
                     phase_d = '0;
                     stage_d = shifted;
                     if (shifted == '0) begin
                        state_d = S_RUN;
                        ready_d = 1'b1;
                     end
                  end else begin
                     phase_d = phase_q + 1'b1;
                  end
               end
            end
         end

         default: begin
            // S_RESET and the unused encodings 5-7.
            state_d = S_WAIT_LOCK;
            stage_d = ALL_ON;
            ready_d = 1'b0;
            filt_d  = '0;
            phase_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_RESET;
         stage_q <= ALL_ON;
         ready_q <= 1'b0;
         filt_q  <= '0;
         phase_q <= '0;
         loss_q  <= '0;
      end else begin
         state_q <= state_d;
         stage_q <= stage_d;
         ready_q <= ready_d;
         filt_q  <= filt_d;
         phase_q <= phase_d;
         loss_q  <= loss_d;
      end
   end

   assign rst_o           = stage_q;
   assign ready_o         = ready_q;
   assign state_o         = state_q;
   assign lock_loss_cnt_o = loss_q;

endmodule

// File: tb/tb_iob_reset_sequencer.sv
// Bench for iob_reset_sequencer: a directed vector table for the release/loss/sw-reset
// timeline, then random lock/sw/rst traffic checked against a timeline model.
module tb_iob_reset_sequencer;

   localparam int HOLD = 16;
   localparam int GAP  = 8;
   localparam int FILT = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_i, lock_i, sw_rst_i;
   logic [2:0] rst3;
   logic       ready3;
   logic [2:0] state3;
   logic [7:0] loss3;
   logic [0:0] rst1;
   logic       ready1;
   logic [2:0] state1;
   logic [7:0] loss1;

   iob_reset_sequencer #(.N_STAGES(3), .HOLD_CYCLES(HOLD), .STAGE_GAP(GAP), .LOCK_FILT(FILT)) dut (
      .clk_i(clk), .rst_i(rst_i), .lock_i(lock_i), .sw_rst_i(sw_rst_i),
      .rst_o(rst3), .ready_o(ready3), .state_o(state3), .lock_loss_cnt_o(loss3)
   );

   iob_reset_sequencer #(.N_STAGES(1), .HOLD_CYCLES(HOLD), .STAGE_GAP(GAP), .LOCK_FILT(FILT)) dut1 (
      .clk_i(clk), .rst_i(rst_i), .lock_i(lock_i), .sw_rst_i(sw_rst_i),
      .rst_o(rst1), .ready_o(ready1), .state_o(state1), .lock_loss_cnt_o(loss1)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Directed vectors: apply inputs for n edges, then check the outputs.
   typedef struct {
      int         n;
      logic       rst;
      logic       lock;
      logic       sw;
      logic [2:0] e_rst;
      logic       e_rdy;
      logic [2:0] e_st;
      logic [7:0] e_loss;
      logic       e1_rdy;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(int n, logic r, logic l, logic s, logic [2:0] er, logic erdy,
                               logic [2:0] est, logic [7:0] eloss, logic e1);
      vec_t v;
      v.n = n; v.rst = r; v.lock = l; v.sw = s;
      v.e_rst = er; v.e_rdy = erdy; v.e_st = est; v.e_loss = eloss; v.e1_rdy = e1;
      vecs.push_back(v);
   endfunction

   // Timeline model: mode 0 reset, 1 waiting for lock, 2 sequencing with
   // m_t = edges since lock was qualified (or since a sw reset restarted the hold).
   int   m_mode = 0, m_ones = 0, m_zeros = 0, m_t = 0, m_loss = 0;
   logic m_s1 = 1'b0, m_s2 = 1'b0;

   function automatic void model_step(input logic r, input logic l, input logic s);
      logic smp;
      smp  = m_s2;
      m_s2 = m_s1;
      m_s1 = l;
      if (r) begin
         m_mode = 0; m_loss = 0; m_ones = 0; m_zeros = 0; m_t = 0;
      end else if (m_mode == 0) begin
         m_mode = 1; m_ones = 0;
      end else if (m_mode == 1) begin
         if (smp) m_ones++; else m_ones = 0;
         if (m_ones == FILT) begin
            m_mode = 2; m_t = 0; m_zeros = 0;
         end
      end else begin
         if (!smp) m_zeros++; else m_zeros = 0;
         if (m_zeros == FILT) begin
            m_mode = 1; m_ones = 0;
            if (m_loss < 255) m_loss++;
         end else if (s) begin
            m_zeros = 0; m_ones = 0; m_t = 0;
            m_mode = smp ? 2 : 1;
         end else if (m_t < 100000) begin
            m_t++;
         end
      end
   endfunction

   task automatic model_out(input int n, output logic [7:0] r, output logic rdy, output logic [2:0] st);
      r   = 8'((1 << n) - 1);
      rdy = 1'b0;
      st  = (m_mode == 0) ? 3'd0 : 3'd1;
      if (m_mode == 2) begin
         for (int k = 0; k < n; k++)
            if (m_t >= HOLD + GAP * k) r[k] = 1'b0;
         rdy = (m_t >= HOLD + GAP * (n - 1));
         st  = rdy ? 3'd4 : ((m_t >= HOLD) ? 3'd3 : 3'd2);
      end
   endtask

   task automatic cycle(input logic r, input logic l, input logic s);
      logic [7:0] er;
      logic       erdy;
      logic [2:0] est;
      rst_i = r; lock_i = l; sw_rst_i = s;
      @(posedge clk);
      model_step(r, l, s);
      #1;
      model_out(3, er, erdy, est);
      chk("model_rst3", rst3, er);
      chk("model_ready3", ready3, erdy);
      chk("model_state3", state3, est);
      chk("model_loss3", loss3, m_loss);
      model_out(1, er, erdy, est);
      chk("model_rst1", rst1, er);
      chk("model_ready1", ready1, erdy);
      chk("model_state1", state1, est);
      chk("model_loss1", loss1, m_loss);
   endtask

   initial begin
      logic lk;
      int   run;

      rst_i = 1'b1; lock_i = 1'b1; sw_rst_i = 1'b0;

      // Edge numbers in the notes count from the first edge sampling rst_i=0.
      add( 4, 1, 1, 0, 3'b111, 0, 3'd0, 8'd0, 0);  // held in reset
      add( 1, 0, 1, 0, 3'b111, 0, 3'd1, 8'd0, 0);  // edge 1
      add( 4, 0, 1, 0, 3'b111, 0, 3'd2, 8'd0, 0);  // edge 5: lock qualified
      add(15, 0, 1, 0, 3'b111, 0, 3'd2, 8'd0, 0);  // edge 20
      add( 1, 0, 1, 0, 3'b110, 0, 3'd3, 8'd0, 1);  // edge 21
      add( 7, 0, 1, 0, 3'b110, 0, 3'd3, 8'd0, 1);  // edge 28
      add( 1, 0, 1, 0, 3'b100, 0, 3'd3, 8'd0, 1);  // edge 29
      add( 8, 0, 1, 0, 3'b000, 1, 3'd4, 8'd0, 1);  // edge 37: running
      add( 3, 0, 0, 0, 3'b000, 1, 3'd4, 8'd0, 1);  // 3-cycle dip starts
      add( 5, 0, 1, 0, 3'b000, 1, 3'd4, 8'd0, 1);  // edge 45: dip ignored
      add( 4, 0, 0, 0, 3'b000, 1, 3'd4, 8'd0, 1);  // 4-cycle dip
      add( 2, 0, 1, 0, 3'b111, 0, 3'd1, 8'd1, 0);  // edge 51: lock loss
      add( 4, 0, 1, 0, 3'b111, 0, 3'd2, 8'd1, 0);  // edge 55: requalified
      add(16, 0, 1, 0, 3'b110, 0, 3'd3, 8'd1, 1);  // edge 71
      add( 8, 0, 1, 0, 3'b100, 0, 3'd3, 8'd1, 1);  // edge 79
      add( 1, 0, 1, 1, 3'b111, 0, 3'd2, 8'd1, 0);  // edge 80: sw reset in RELEASE
      add(15, 0, 1, 0, 3'b111, 0, 3'd2, 8'd1, 0);  // edge 95
      add( 1, 0, 1, 0, 3'b110, 0, 3'd3, 8'd1, 1);  // edge 96
      add(16, 0, 1, 0, 3'b000, 1, 3'd4, 8'd1, 1);  // edge 112
      add( 5, 0, 0, 0, 3'b000, 1, 3'd4, 8'd1, 1);  // edge 117: 3 low samples
      add( 1, 0, 0, 1, 3'b111, 0, 3'd1, 8'd2, 0);  // edge 118: loss beats sw reset
      add( 2, 0, 0, 0, 3'b111, 0, 3'd1, 8'd2, 0);  // edge 120
      add( 3, 0, 1, 0, 3'b111, 0, 3'd1, 8'd2, 0);  // edge 123: 3-cycle lock pulse
      add( 3, 0, 0, 0, 3'b111, 0, 3'd1, 8'd2, 0);  // edge 126: pulse did not qualify
      add( 3, 0, 1, 0, 3'b111, 0, 3'd1, 8'd2, 0);  // edge 129
      add( 2, 0, 1, 0, 3'b111, 0, 3'd1, 8'd2, 0);  // edge 131: 3 high samples
      add( 1, 0, 1, 0, 3'b111, 0, 3'd2, 8'd2, 0);  // edge 132: 4th high sample
      add(15, 0, 1, 0, 3'b111, 0, 3'd2, 8'd2, 0);  // edge 147
      add( 1, 0, 1, 0, 3'b110, 0, 3'd3, 8'd2, 1);  // edge 148
      add( 1, 0, 1, 1, 3'b111, 0, 3'd2, 8'd2, 0);  // edge 149: sw reset back to HOLD
      add( 1, 1, 1, 0, 3'b111, 0, 3'd0, 8'd0, 0);  // edge 150: rst_i during HOLD
      add( 1, 0, 1, 0, 3'b111, 0, 3'd1, 8'd0, 0);  // edge 151

      foreach (vecs[i]) begin
         rst_i = vecs[i].rst; lock_i = vecs[i].lock; sw_rst_i = vecs[i].sw;
         repeat (vecs[i].n) @(posedge clk);
         #1;
         chk($sformatf("row%0d_rst", i), rst3, vecs[i].e_rst);
         chk($sformatf("row%0d_ready", i), ready3, vecs[i].e_rdy);
         chk($sformatf("row%0d_state", i), state3, vecs[i].e_st);
         chk($sformatf("row%0d_loss", i), loss3, vecs[i].e_loss);
         chk($sformatf("row%0d_n1_ready", i), ready1, vecs[i].e1_rdy);
         chk($sformatf("row%0d_n1_rst", i), rst1, !vecs[i].e1_rdy);
      end

      // Random lock runs (short dips and long stretches) with sparse sw/rst pulses.
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0);
      lk  = 1'b1;
      run = 0;
      for (int i = 0; i < 4000; i++) begin
         if (run == 0) begin
            lk  = ~lk;
            run = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 6) : $urandom_range(8, 60);
         end
         run--;
         cycle($urandom_range(0, 599) == 0, lk, $urandom_range(0, 39) == 0);
      end

      // 300 qualify/lose cycles drive the loss counter into saturation.
      for (int i = 0; i < 2; i++) cycle(1'b1, 1'b1, 1'b0);
      for (int e = 0; e < 300; e++) begin
         for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b0);
         for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b0);
      end
      chk("loss_saturated", loss3, 255);
      chk("loss_saturated_n1", loss1, 255);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
